// File: rtl/serial_frame_rx.sv
// rtl/serial_frame_rx.sv - UART-style serial frame receiver with single-word output buffer
// Two-flop input synchronizer, mid-bit sampling FSM, valid/ready output with overrun and framing-error pulses.
module serial_frame_rx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              din,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              frame_err,
  output logic              overrun
);

  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

  logic [1:0]        rst_pipe;
  logic              rst_n;
  logic              din_s1;
  logic              din_s2;
  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] shreg;
  logic              frame_done;

  // Assertion is immediate; release reaches the rest of the logic two edges later.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rst_pipe <= 2'b00;
    else        rst_pipe <= {rst_pipe[0], 1'b1};
  end

  assign rst_n = rst_pipe[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      din_s1 <= 1'b1;
      din_s2 <= 1'b1;
    end else begin
      din_s1 <= din;
      din_s2 <= din_s1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      idx        <= '0;
      shreg      <= '0;
      frame_err  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_err  <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (!din_s2) begin
            state <= START;
            cnt   <= '0;
          end
        end
        START: begin
          if (cnt == HALF_M1) begin
            cnt   <= '0;
            idx   <= '0;
            state <= din_s2 ? IDLE : DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == FULL_M1) begin
            cnt        <= '0;
            shreg[idx] <= din_s2;
            if (idx == LAST_IDX) state <= STOP;
            else                 idx   <= idx + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == FULL_M1) begin
            cnt <= '0;
            if (din_s2) begin
              frame_done <= 1'b1;
              state      <= IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= WAIT_HIGH;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_HIGH: begin
          if (din_s2) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // shreg is untouched until the next frame reaches DATA, so it is still valid here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (frame_done) begin
        if (!dout_valid || dout_ready) begin
          dout       <= shreg;
          dout_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (dout_valid && dout_ready) begin
        dout_valid <= 1'b0;
      end
    end
  end

endmodule
